// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller
// between the pipeline MEM stage and a line-wide (256-bit) off-chip memory.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   cpu_addr_i          byte address of the load/store
//   cpu_data_i          store data
//   cpu_MemRead_i       load request
//   cpu_MemWrite_i      store request (wins when both requests are set)
//   cpu_data_o          load data on a hit, 0 otherwise (combinational)
//   cpu_stall_o         pipeline freeze while a miss is serviced
//   mem_enable_o        memory request valid (registered)
//   mem_write_o         1 = line write-back, 0 = line fill
//   mem_addr_o          line-aligned byte address
//   mem_data_o          victim line for write-back
//   mem_data_i          fill line
//   mem_ack_i           one-cycle completion pulse from memory
module dcache_ctrl #(
   parameter int LINES = 32,
   parameter int IDX_W = 5
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [31:0]  cpu_addr_i,
   input  logic [31:0]  cpu_data_i,
   input  logic         cpu_MemRead_i,
   input  logic         cpu_MemWrite_i,
   output logic [31:0]  cpu_data_o,
   output logic         cpu_stall_o,
   output logic         mem_enable_o,
   output logic         mem_write_o,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o,
   input  logic [255:0] mem_data_i,
   input  logic         mem_ack_i
);

   localparam int TAG_W = 32 - IDX_W - 5;

   typedef enum logic [1:0] {IDLE, WB, ALLOC} state_t;

   state_t             state_reg;
   logic [LINES-1:0]   valid_reg;
   logic [LINES-1:0]   dirty_reg;
   logic [TAG_W-1:0]   tag_mem [LINES];
   logic [255:0]       line_rd;

   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   cpu_tag;
   logic [2:0]         word_sel;
   logic               req;
   logic               hit;
   logic               idle;
   logic               hit_write;
   logic               fill;
   logic               unused_addr_bits;

   assign word_sel = cpu_addr_i[4:2];
   assign idx      = cpu_addr_i[IDX_W+4:5];
   assign cpu_tag  = cpu_addr_i[31:IDX_W+5];
   assign unused_addr_bits = ^cpu_addr_i[1:0];

   assign req  = cpu_MemRead_i | cpu_MemWrite_i;
   assign idle = (state_reg == IDLE);
   assign hit  = valid_reg[idx] && (tag_mem[idx] == cpu_tag);

   // Storage write strobes; reset takes priority so an abandoned fill
   // never lands in the arrays.
   assign hit_write = ~rst_i & idle & req & hit & cpu_MemWrite_i;
   assign fill      = ~rst_i & (state_reg == ALLOC) & mem_ack_i;

   // A simultaneous read+write request is a store, so it returns no data.
   assign cpu_data_o  = (cpu_MemRead_i & ~cpu_MemWrite_i & hit & idle) ?
                        line_rd[{word_sel, 5'b0} +: 32] : 32'h0;
   assign cpu_stall_o = req & ~(hit & idle);

   // Line data is kept as eight word-wide arrays so a store touches only
   // its own word while a fill writes all eight at once.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_word
         logic [31:0] word_mem [LINES];
         always_ff @(posedge clk_i) begin
            if (fill)
               word_mem[idx] <= mem_data_i[32*gi +: 32];
            else if (hit_write && (word_sel == 3'(gi)))
               word_mem[idx] <= cpu_data_i;
         end
         assign line_rd[32*gi +: 32] = word_mem[idx];
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (fill)
         tag_mem[idx] <= cpu_tag;
   end

   // Controller FSM. The mem_* outputs are loaded on the transition into
   // each state, so they are valid for the whole time the state is held.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= IDLE;
         valid_reg    <= '0;
         dirty_reg    <= '0;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= 32'h0;
         mem_data_o   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req) begin
                  if (hit) begin
                     if (cpu_MemWrite_i)
                        dirty_reg[idx] <= 1'b1;
                  end else if (valid_reg[idx] && dirty_reg[idx]) begin
                     state_reg    <= WB;
                     mem_enable_o <= 1'b1;
                     mem_write_o  <= 1'b1;
                     mem_addr_o   <= {tag_mem[idx], idx, 5'b0};
                     mem_data_o   <= line_rd;
                  end else begin
                     state_reg    <= ALLOC;
                     mem_enable_o <= 1'b1;
                     mem_write_o  <= 1'b0;
                     mem_addr_o   <= {cpu_tag, idx, 5'b0};
                     mem_data_o   <= '0;
                  end
               end
            end
            WB: begin
               if (mem_ack_i) begin
                  state_reg   <= ALLOC;
                  mem_write_o <= 1'b0;
                  mem_addr_o  <= {cpu_tag, idx, 5'b0};
                  mem_data_o  <= '0;
               end
            end
            ALLOC: begin
               if (mem_ack_i) begin
                  state_reg      <= IDLE;
                  valid_reg[idx] <= 1'b1;
                  dirty_reg[idx] <= 1'b0;
                  mem_enable_o   <= 1'b0;
                  mem_write_o    <= 1'b0;
                  mem_addr_o     <= 32'h0;
                  mem_data_o     <= '0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: table-driven directed cases plus randomized accesses
// checked against an access-level model (word-addressed golden memory and
// per-index occupancy) for dcache_ctrl with LINES=32.
module tb_dcache_ctrl;
   localparam int LINES = 32;
   localparam int IDX_W = 5;

   logic         clk = 1'b0;
   logic         rst_i;
   logic [31:0]  cpu_addr_i, cpu_data_i;
   logic         cpu_MemRead_i, cpu_MemWrite_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic         mem_enable_o, mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o, mem_data_i;
   logic         mem_ack_i;

   always #5 clk = ~clk;

   dcache_ctrl #(.LINES(LINES), .IDX_W(IDX_W)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
      .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
      .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   int tests = 0;
   int fails = 0;
   int alloc_delay = 1;
   int wb_delay = 1;

   logic [255:0] backing [int unsigned];
   logic [31:0]  golden  [int unsigned];
   bit           m_valid [LINES];
   bit           m_dirty [LINES];
   int unsigned  m_tag   [LINES];

   typedef struct {
      logic [31:0]  addr;
      logic [31:0]  wdata;
      logic         rd;
      logic         wr;
      int           ad;
      int           wd;
      int           exp_stall;
      logic [31:0]  exp_data;
      logic         exp_wb;
      logic [31:0]  exp_wb_addr;
      logic [255:0] exp_wb_data;
      logic [31:0]  exp_alloc_addr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic [31:0] addr, logic [31:0] wdata, logic rd, logic wr,
                               int ad, int wd, int st, logic [31:0] dat, logic wb,
                               logic [31:0] wba, logic [255:0] wbd, logic [31:0] ala);
      vec_t v;
      v.addr = addr; v.wdata = wdata; v.rd = rd; v.wr = wr; v.ad = ad; v.wd = wd;
      v.exp_stall = st; v.exp_data = dat; v.exp_wb = wb; v.exp_wb_addr = wba;
      v.exp_wb_data = wbd; v.exp_alloc_addr = ala;
      return v;
   endfunction

   function automatic logic [255:0] init_line(logic [31:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++)
         l[32*w +: 32] = la ^ (32'(w) << 24) ^ 32'h5A5A0000;
      return l;
   endfunction

   function automatic logic [255:0] get_line(logic [31:0] la);
      if (backing.exists(la)) return backing[la];
      return init_line(la);
   endfunction

   function automatic logic [31:0] gold_word(logic [31:0] a);
      logic [31:0]  wa;
      logic [255:0] l;
      int           w;
      wa = {a[31:2], 2'b0};
      if (golden.exists(wa)) return golden[wa];
      l = get_line({a[31:5], 5'b0});
      w = int'(a[4:2]);
      return l[32*w +: 32];
   endfunction

   function automatic logic [255:0] gold_line(logic [31:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++)
         l[32*w +: 32] = gold_word(la + 32'(4*w));
      return l;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory responder: acks after the configured number of cycles in a state.
   initial begin
      int cnt;
      cnt = 0;
      mem_ack_i = 1'b0;
      mem_data_i = '0;
      forever begin
         @(posedge clk);
         #2;
         mem_ack_i = 1'b0;
         if (rst_i || !mem_enable_o) begin
            cnt = 0;
         end else begin
            cnt++;
            if (cnt >= (mem_write_o ? wb_delay : alloc_delay)) begin
               if (mem_write_o) backing[mem_addr_o] = mem_data_o;
               else             mem_data_i = get_line(mem_addr_o);
               mem_ack_i = 1'b1;
               cnt = 0;
            end
         end
      end
   end

   // Starts and ends 1 time unit after a rising edge.
   task automatic apply(input vec_t v, input int n);
      int           cyc;
      bit           done;
      logic         seen_wb, seen_alloc, en_done;
      logic [31:0]  wb_a, al_a, d;
      logic [255:0] wb_d;
      cyc = 0; done = 0; seen_wb = 0; seen_alloc = 0;
      wb_a = '1; al_a = '1; wb_d = '0;
      alloc_delay = v.ad;
      wb_delay = v.wd;
      cpu_addr_i = v.addr;
      cpu_data_i = v.wdata;
      cpu_MemRead_i = v.rd;
      cpu_MemWrite_i = v.wr;
      while (!done) begin
         @(negedge clk);
         if (!cpu_stall_o) begin
            done = 1;
         end else begin
            cyc++;
            if (mem_enable_o && mem_write_o && !seen_wb) begin
               seen_wb = 1; wb_a = mem_addr_o; wb_d = mem_data_o;
            end
            if (mem_enable_o && !mem_write_o && !seen_alloc) begin
               seen_alloc = 1; al_a = mem_addr_o;
            end
            if (cyc > 200) begin
               tests++; fails++;
               $display("FAIL stall_timeout txn %0d: stall still high after %0d cycles, required release", n, cyc);
               done = 1;
            end
         end
      end
      d = cpu_data_o;
      en_done = mem_enable_o;
      chk("stall_cycles", 256'(cyc), 256'(v.exp_stall));
      chk("cpu_data", 256'(d), 256'(v.exp_data));
      chk("mem_enable_idle", 256'(en_done), 256'(0));
      chk("wb_seen", 256'(seen_wb), 256'(v.exp_wb));
      if (v.exp_wb) begin
         chk("wb_addr", 256'(wb_a), 256'(v.exp_wb_addr));
         chk("wb_data", wb_d, v.exp_wb_data);
      end
      if (v.exp_stall != 0)
         chk("alloc_addr", 256'(al_a), 256'(v.exp_alloc_addr));
      $display("[TB] txn %0d addr=%h rd=%0d wr=%0d stall=%0d data=%h", n, v.addr, v.rd, v.wr, cyc, d);
      @(posedge clk);
      #1;
      cpu_MemRead_i = 1'b0;
      cpu_MemWrite_i = 1'b0;
   endtask

   initial begin
      vec_t rv;
      int unsigned tg, ix, w, op;
      logic [31:0] wa;

      backing[32'h40]   = {160'h0, 32'h0BADF00D, 32'hDEADBEEF, 32'h0};
      backing[32'h440]  = {192'h0, 32'hCAFE0444, 32'h0};
      backing[32'h80]   = '0;
      backing[32'hC0]   = '0;
      backing[32'h10C0] = {192'h0, 32'h10C01111, 32'h0};
      backing[32'h480]  = '0;

      //         addr          wdata         rd wr ad wd st data          wb wb_addr   wb_data                                          alloc
      tbl.push_back(mk(32'h44,   32'h0,        1, 0, 3, 1, 4, 32'hDEADBEEF, 0, 32'h0,  '0,                                              32'h40));
      tbl.push_back(mk(32'h48,   32'h0,        1, 0, 1, 1, 0, 32'h0BADF00D, 0, 32'h0,  '0,                                              32'h0));
      tbl.push_back(mk(32'h44,   32'h12345678, 0, 1, 1, 1, 0, 32'h0,        0, 32'h0,  '0,                                              32'h0));
      tbl.push_back(mk(32'h444,  32'h0,        1, 0, 1, 2, 4, 32'hCAFE0444, 1, 32'h40, {160'h0, 32'h0BADF00D, 32'h12345678, 32'h0}, 32'h440));
      tbl.push_back(mk(32'h80,   32'h55AA0080, 0, 1, 2, 1, 3, 32'h0,        0, 32'h0,  '0,                                              32'h80));
      tbl.push_back(mk(32'h80,   32'h0,        1, 0, 1, 1, 0, 32'h55AA0080, 0, 32'h0,  '0,                                              32'h0));
      tbl.push_back(mk(32'hC4,   32'h0,        1, 0, 1, 1, 2, 32'h0,        0, 32'h0,  '0,                                              32'hC0));
      tbl.push_back(mk(32'hC4,   32'h77770084, 1, 1, 1, 1, 0, 32'h0,        0, 32'h0,  '0,                                              32'h0));
      tbl.push_back(mk(32'h10C4, 32'h0,        1, 0, 1, 1, 3, 32'h10C01111, 1, 32'hC0, {192'h0, 32'h77770084, 32'h0},               32'h10C0));
      tbl.push_back(mk(32'h480,  32'h0,        1, 0, 1, 1, 3, 32'h0,        1, 32'h80, {224'h0, 32'h55AA0080},                      32'h480));
      tbl.push_back(mk(32'h444,  32'hABCD0444, 0, 1, 1, 1, 0, 32'h0,        0, 32'h0,  '0,                                              32'h0));
      // After the mid-fill reset: the dirty line at index 2 is gone without write-back.
      tbl.push_back(mk(32'h44,   32'h0,        1, 0, 1, 1, 2, 32'h12345678, 0, 32'h0,  '0,                                              32'h40));
      tbl.push_back(mk(32'h10C4, 32'h0,        1, 0, 2, 1, 3, 32'h10C01111, 0, 32'h0,  '0,                                              32'h10C0));

      rst_i = 1'b1;
      cpu_addr_i = '0; cpu_data_i = '0; cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk("reset_mem_enable", 256'(mem_enable_o), 256'(0));
      chk("reset_mem_write", 256'(mem_write_o), 256'(0));
      chk("reset_mem_addr", 256'(mem_addr_o), 256'(0));
      chk("reset_mem_data", mem_data_o, 256'(0));
      chk("reset_stall", 256'(cpu_stall_o), 256'(0));
      chk("reset_cpu_data", 256'(cpu_data_o), 256'(0));
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) apply(tbl[i], i);

      // Reset during the second fill cycle abandons the transfer.
      alloc_delay = 10;
      cpu_addr_i = 32'h204;
      cpu_MemRead_i = 1'b1;
      @(negedge clk);
      chk("rstseq_idle_stall", 256'(cpu_stall_o), 256'(1));
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstseq_alloc_enable", 256'(mem_enable_o), 256'(1));
      chk("rstseq_alloc_addr", 256'(mem_addr_o), 256'(32'h200));
      @(posedge clk); #1;
      rst_i = 1'b1;
      @(negedge clk);
      chk("rstseq_alloc2_enable", 256'(mem_enable_o), 256'(1));
      @(posedge clk); #1;
      rst_i = 1'b0;
      cpu_MemRead_i = 1'b0;
      @(negedge clk);
      chk("rstseq_after_enable", 256'(mem_enable_o), 256'(0));
      chk("rstseq_after_stall", 256'(cpu_stall_o), 256'(0));
      @(posedge clk); #1;

      for (int i = 11; i < tbl.size(); i++) apply(tbl[i], i);

      // Randomized phase from a clean cache.
      rst_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      golden.delete();
      for (int i = 0; i < LINES; i++) begin
         m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0;
      end
      for (int t = 0; t < 300; t++) begin
         tg = $urandom_range(0, 3);
         ix = $urandom_range(0, 3);
         w  = $urandom_range(0, 7);
         op = $urandom_range(0, 3);
         rv.addr  = 32'((tg << 10) | (ix << 5) | (w << 2) | $urandom_range(0, 3));
         wa = {rv.addr[31:2], 2'b0};
         rv.wdata = $urandom;
         rv.rd = (op != 1);
         rv.wr = (op == 1 || op == 2);
         rv.ad = $urandom_range(1, 4);
         rv.wd = $urandom_range(1, 4);
         rv.exp_alloc_addr = {rv.addr[31:5], 5'b0};
         rv.exp_wb = 0;
         rv.exp_wb_addr = '0;
         rv.exp_wb_data = '0;
         if (m_valid[ix] && m_tag[ix] == tg) begin
            rv.exp_stall = 0;
         end else begin
            rv.exp_wb = m_valid[ix] && m_dirty[ix];
            if (rv.exp_wb) begin
               rv.exp_wb_addr = 32'((m_tag[ix] << 10) | (ix << 5));
               rv.exp_wb_data = gold_line(rv.exp_wb_addr);
            end
            rv.exp_stall = 1 + (rv.exp_wb ? rv.wd : 0) + rv.ad;
            m_valid[ix] = 1;
            m_tag[ix] = tg;
            m_dirty[ix] = 0;
         end
         rv.exp_data = (rv.rd && !rv.wr) ? gold_word(rv.addr) : 32'h0;
         if (rv.wr) begin
            golden[wa] = rv.wdata;
            m_dirty[ix] = 1;
         end
         apply(rv, 100 + t);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
